object_centroid_tracker: RTL and testbench
==========================================

# object_centroid_tracker

Upstream stage of the on-screen tracking marker. It consumes the classified camera pixel stream and accumulates the coordinates of every pixel flagged as object colour over one frame. At frame end it divides the sums by the pixel count and produces the marker position (`x_pos`, `y_pos`) plus the lock flag (`en`) that drive the marker overlay. Lock is green when `en`=1 and red when `en`=0.

## Interface
Parameters:
- `WIDTH`, default 320: active columns; pixels with `pix_x` ≥ `WIDTH` are ignored.
- `HEIGHT`, default 240: active rows; pixels with `pix_y` ≥ `HEIGHT` are ignored.
- `MIN_COUNT`, default 64: minimum matched pixels per frame for lock; must be ≥ 1.

Ports:
- `clock` in 1: single clock domain for the whole block.
- `reset_n` in 1: reset, asynchronous, active-low.
- `pix_valid` in 1: `pix_x`/`pix_y`/`pix_match` are valid this cycle.
- `pix_x` in 9: column of the current pixel.
- `pix_y` in 8: row of the current pixel.
- `pix_match` in 1: current pixel is classified as object colour.
- `frame_end` in 1: single-cycle pulse marking the end of a frame.
- `x_pos` out 9: centroid column, registered.
- `y_pos` out 8: centroid row, registered.
- `en` out 1: lock flag; 1 when the last evaluated frame had ≥ `MIN_COUNT` matches.
- `update` out 1: single-cycle pulse when `x_pos`/`y_pos`/`en` have just been refreshed.
- `busy` out 1: high while the divide is in progress.

## Operation
- Accumulators:
  - `cnt`: 17 bits, max 76800.
  - `sum_x`: 25 bits, max 319·76800.
  - `sum_y`: 25 bits.
  - Increment only when `pix_valid & pix_match` and the coordinates are in range.
- FSM states: ACCUM, DIVIDE, PUBLISH.
- ACCUM, on `frame_end`:
  - Copy the accumulators to snapshot registers, then clear the accumulators.
  - If snapshot `cnt` < `MIN_COUNT`, go to PUBLISH with `en_next`=0.
  - Otherwise go to DIVIDE.
- Same-cycle `pix_valid & pix_match` with `frame_end`: that pixel is included in the snapshot. The next frame starts from zero.
- DIVIDE: two restoring dividers run in parallel, `sum_x/cnt` and `sum_y/cnt`. Each takes 25 iterations, one quotient bit per cycle, MSB first. The result is a truncated quotient.
- Quotient widths: `x_pos` takes the low 9 bits and `y_pos` the low 8 bits. By construction the quotients are < `WIDTH` and < `HEIGHT`.
- PUBLISH (one cycle):
  - Load `en`, and load `x_pos`/`y_pos` only if `en_next`=1.
  - Pulse `update` and return to ACCUM.
- Below threshold, `x_pos`/`y_pos` hold their previous values and `en` goes 0.
- Accumulation continues in every state. Pixels arriving during DIVIDE/PUBLISH belong to the next frame.
- A `frame_end` arriving outside ACCUM (overrun) is not snapshotted and produces no update. The accumulators are still cleared, so that frame is discarded.

## Timing
- Reset values:
  - `x_pos`=`WIDTH`/2 (160).
  - `y_pos`=`HEIGHT`/2 (120).
  - `en`=0, `update`=0, `busy`=0.
  - Accumulators 0; state ACCUM.
- Above threshold, with `frame_end` sampled at edge T:
  - `busy`=1 after edges T+1..T+25.
  - PUBLISH is entered after edge T+25.
  - New outputs and `update`=1 are visible after edge T+26, and `update` drops after T+27.
- Below threshold: `en`=0 and `update`=1 are visible after edge T+1. `busy` stays 0.
- All outputs are registered; no combinational path from inputs.
- Asserting `reset_n` mid-DIVIDE aborts immediately to reset values; no `update` pulse is issued for the aborted frame.

## Structure
- `tracker_pkg` holds:
  - the FSM state enum;
  - width constants: `CNT_W`=17, `SUM_W`=25, `X_W`=9, `Y_W`=8.
- One sub-module, `seq_divider`:
  - parameterised dividend and divisor widths;
  - `start` and `done` handshake;
  - instantiated twice, once for x and once for y.
- Total RTL is expected in the 150–250 line range.

## Test plan
- Reset with no frames → `x_pos`=160, `y_pos`=120, `en`=0, `update`=0.
- 8×8 matched block at x 100..107, y 50..57 (64 pixels), then `frame_end` → `update` exactly 26 cycles later with `x_pos`=103, `y_pos`=53, `en`=1.
- Next frame with 63 matched pixels → `update` 1 cycle after `frame_end`, `en`=0, `x_pos`/`y_pos` hold 103/53.
- Full-screen match (76800 pixels) → `x_pos`=159, `y_pos`=119, `en`=1. Also checks truncation and no overflow at maximum sums.
- Matched pixel with `pix_x`=320 or `pix_y`=240 mixed into the 64-pixel block → ignored; result identical to scenario 2. Same-cycle `pix_match` with `frame_end` → that pixel counted in the ending frame.
- `frame_end` pulsed at T+10 during DIVIDE → exactly one `update` (at T+26, for the first frame); the next `update` requires a later `frame_end`. `reset_n` low at T+12 → outputs back to 160/120/0, no `update`.

Source files
------------

// File: rtl/object_centroid_tracker_pkg.sv
// Shared widths and FSM state encoding for the centroid tracker.
package tracker_pkg;
    localparam int unsigned CNT_W = 17;
    localparam int unsigned SUM_W = 25;
    localparam int unsigned X_W   = 9;
    localparam int unsigned Y_W   = 8;

    typedef enum logic [1:0] {
        ACCUM,
        DIVIDE,
        PUBLISH
    } tracker_state_e;
endpackage

// File: rtl/object_centroid_tracker_if.sv
// Pixel stream in, marker position out; master is the pixel source.
interface object_centroid_tracker_if;
    import tracker_pkg::*;

    logic           pix_valid;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           pix_match;
    logic           frame_end;
    logic [X_W-1:0] x_pos;
    logic [Y_W-1:0] y_pos;
    logic           en;
    logic           update;
    logic           busy;

    modport master (
        output pix_valid, pix_x, pix_y, pix_match, frame_end,
        input  x_pos, y_pos, en, update, busy
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_match, frame_end,
        output x_pos, y_pos, en, update, busy
    );
endinterface

// File: rtl/object_centroid_tracker_seq_divider.sv
// Restoring divider, one quotient bit per cycle MSB first; DVD_W cycles after start.
module seq_divider #(
    parameter int unsigned DVD_W = 25,
    parameter int unsigned DVS_W = 17,
    parameter int unsigned Q_W   = DVD_W
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             start_i,
    input  logic [DVD_W-1:0] dividend_i,
    input  logic [DVS_W-1:0] divisor_i,
    output logic             done_o,
    output logic [Q_W-1:0]   quotient_o
);
    localparam int unsigned ITER_W = $clog2(DVD_W);

    logic [DVD_W-1:0]  quo_q;
    logic [DVS_W-1:0]  rem_q, rem_d, dvs_q;
    logic [ITER_W-1:0] iter_q;
    logic              run_q;
    logic [DVS_W:0]    trial;
    logic              ge;

    // Remainder stays below the divisor, so DVS_W bits plus the shifted-in bit suffice.
    always_comb begin
        trial = {rem_q, quo_q[DVD_W-1]};
        ge    = (trial >= {1'b0, dvs_q});
        rem_d = ge ? DVS_W'(trial - {1'b0, dvs_q}) : trial[DVS_W-1:0];
    end

    assign done_o     = run_q && (iter_q == ITER_W'(DVD_W - 1));
    assign quotient_o = quo_q[Q_W-1:0];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            iter_q <= '0;
            run_q  <= 1'b0;
        end else if (start_i) begin
            quo_q  <= dividend_i;
            rem_q  <= '0;
            dvs_q  <= divisor_i;
            iter_q <= '0;
            run_q  <= 1'b1;
        end else if (run_q) begin
            rem_q  <= rem_d;
            quo_q  <= {quo_q[DVD_W-2:0], ge};
            iter_q <= iter_q + ITER_W'(1);
            if (done_o) run_q <= 1'b0;
        end
    end
endmodule

// File: rtl/object_centroid_tracker.sv
// Accumulates matched pixel coordinates per frame and publishes their centroid and lock flag.
module object_centroid_tracker
    import tracker_pkg::*;
#(
    parameter int unsigned WIDTH     = 320,
    parameter int unsigned HEIGHT    = 240,
    parameter int unsigned MIN_COUNT = 64
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic           pix_valid,
    input  logic [X_W-1:0] pix_x,
    input  logic [Y_W-1:0] pix_y,
    input  logic           pix_match,
    input  logic           frame_end,
    output logic [X_W-1:0] x_pos,
    output logic [Y_W-1:0] y_pos,
    output logic           en,
    output logic           update,
    output logic           busy
);
    localparam logic [X_W:0]     WIDTH_L  = (X_W + 1)'(WIDTH);
    localparam logic [Y_W:0]     HEIGHT_L = (Y_W + 1)'(HEIGHT);
    localparam logic [CNT_W-1:0] MIN_L    = CNT_W'(MIN_COUNT);

    tracker_state_e   state_q;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_snap;
    logic [SUM_W-1:0] sum_x_q, sum_x_d, sum_x_snap;
    logic [SUM_W-1:0] sum_y_q, sum_y_d, sum_y_snap;
    logic             hit, lock, div_start, done_x, done_y, en_next_q;
    logic [X_W-1:0]   quo_x, x_pos_q;
    logic [Y_W-1:0]   quo_y, y_pos_q;
    logic             en_q, update_q, busy_q;

    // The snapshot includes a pixel that coincides with frame_end; the next frame starts at zero.
    always_comb begin
        hit        = pix_valid & pix_match & ({1'b0, pix_x} < WIDTH_L) & ({1'b0, pix_y} < HEIGHT_L);
        cnt_snap   = cnt_q + CNT_W'(hit);
        sum_x_snap = sum_x_q + (hit ? SUM_W'(pix_x) : '0);
        sum_y_snap = sum_y_q + (hit ? SUM_W'(pix_y) : '0);
        cnt_d      = frame_end ? '0 : cnt_snap;
        sum_x_d    = frame_end ? '0 : sum_x_snap;
        sum_y_d    = frame_end ? '0 : sum_y_snap;
        lock       = (cnt_snap >= MIN_L);
        div_start  = (state_q == ACCUM) && frame_end && lock;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q   <= '0;
            sum_x_q <= '0;
            sum_y_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            sum_x_q <= sum_x_d;
            sum_y_q <= sum_y_d;
        end
    end

    seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(X_W)) u_div_x (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (div_start),
        .dividend_i (sum_x_snap),
        .divisor_i  (cnt_snap),
        .done_o     (done_x),
        .quotient_o (quo_x)
    );

    seq_divider #(.DVD_W(SUM_W), .DVS_W(CNT_W), .Q_W(Y_W)) u_div_y (
        .clock      (clock),
        .reset_n    (reset_n),
        .start_i    (div_start),
        .dividend_i (sum_y_snap),
        .divisor_i  (cnt_snap),
        .done_o     (done_y),
        .quotient_o (quo_y)
    );

    // busy lags the DIVIDE state by one cycle so it spans the 25 iteration edges.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ACCUM;
            en_next_q <= 1'b0;
            x_pos_q   <= X_W'(WIDTH / 2);
            y_pos_q   <= Y_W'(HEIGHT / 2);
            en_q      <= 1'b0;
            update_q  <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            update_q <= 1'b0;
            busy_q   <= (state_q == DIVIDE);
            case (state_q)
                ACCUM: begin
                    if (frame_end) begin
                        en_next_q <= lock;
                        state_q   <= lock ? DIVIDE : PUBLISH;
                    end
                end
                DIVIDE: begin
                    if (done_x && done_y) state_q <= PUBLISH;
                end
                PUBLISH: begin
                    en_q <= en_next_q;
                    if (en_next_q) begin
                        x_pos_q <= quo_x;
                        y_pos_q <= quo_y;
                    end
                    update_q <= 1'b1;
                    state_q  <= ACCUM;
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

    assign x_pos  = x_pos_q;
    assign y_pos  = y_pos_q;
    assign en     = en_q;
    assign update = update_q;
    assign busy   = busy_q;
endmodule

// File: tb/tb_object_centroid_tracker.sv
// Bench for object_centroid_tracker: frame-level reference model checked every cycle plus directed literal checks.
module tb_object_centroid_tracker;
    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    object_centroid_tracker_if bus();

    object_centroid_tracker #(.WIDTH(320), .HEIGHT(240), .MIN_COUNT(64)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .pix_valid (bus.pix_valid),
        .pix_x     (bus.pix_x),
        .pix_y     (bus.pix_y),
        .pix_match (bus.pix_match),
        .frame_end (bus.frame_end),
        .x_pos     (bus.x_pos),
        .y_pos     (bus.y_pos),
        .en        (bus.en),
        .update    (bus.update),
        .busy      (bus.busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: per-frame sums, and a scheduled publish event.
    int m_cnt = 0, m_sx = 0, m_sy = 0;
    int exp_x = 160, exp_y = 120;
    bit exp_en = 0, exp_upd = 0, exp_busy = 0;
    bit pend = 0, pend_div = 0, pend_en = 0;
    int pend_edge = 0, start_edge = 0, pend_x = 0, pend_y = 0;
    int edge_n = 0;
    bit model_ok = 0;

    always @(posedge clock) begin
        bit accept;
        bit h;
        edge_n++;
        if (!reset_n) begin
            m_cnt = 0; m_sx = 0; m_sy = 0;
            exp_x = 160; exp_y = 120; exp_en = 0; exp_upd = 0; exp_busy = 0;
            pend = 0; pend_div = 0;
            model_ok = 1;
        end else begin
            accept   = !pend;
            exp_busy = pend && pend_div && (edge_n >= start_edge + 1) && (edge_n <= start_edge + 25);
            exp_upd  = 0;
            if (pend && edge_n == pend_edge) begin
                exp_upd = 1;
                exp_en  = pend_en;
                if (pend_en) begin
                    exp_x = pend_x;
                    exp_y = pend_y;
                end
                pend = 0;
            end
            h = bus.pix_valid && bus.pix_match && (bus.pix_x < 320) && (bus.pix_y < 240);
            if (h) begin
                m_cnt++;
                m_sx += int'(bus.pix_x);
                m_sy += int'(bus.pix_y);
            end
            if (bus.frame_end) begin
                if (accept) begin
                    pend       = 1;
                    start_edge = edge_n;
                    if (m_cnt >= 64) begin
                        pend_div  = 1;
                        pend_en   = 1;
                        pend_edge = edge_n + 26;
                        pend_x    = m_sx / m_cnt;
                        pend_y    = m_sy / m_cnt;
                    end else begin
                        pend_div  = 0;
                        pend_en   = 0;
                        pend_edge = edge_n + 1;
                    end
                end
                m_cnt = 0; m_sx = 0; m_sy = 0;
            end
        end
    end

    always @(posedge clock) begin
        #1;
        if (model_ok) begin
            n_checks++;
            if (int'(bus.x_pos) != exp_x || int'(bus.y_pos) != exp_y || bus.en != exp_en ||
                bus.update != exp_upd || bus.busy != exp_busy) begin
                n_errors++;
                $display("FAIL cycle_outputs edge %0d: got x=%0d y=%0d en=%0b upd=%0b busy=%0b, expected x=%0d y=%0d en=%0b upd=%0b busy=%0b",
                         edge_n, bus.x_pos, bus.y_pos, bus.en, bus.update, bus.busy,
                         exp_x, exp_y, exp_en, exp_upd, exp_busy);
            end
        end
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    task automatic drive(input bit v, input int x, input int y, input bit m, input bit fe);
        @(negedge clock);
        bus.pix_valid = v;
        bus.pix_x     = 9'(x);
        bus.pix_y     = 8'(y);
        bus.pix_match = m;
        bus.frame_end = fe;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic block(input int x0, input int y0, input int n, input bit fe_last);
        for (int i = 0; i < n; i++)
            drive(1, x0 + i % 8, y0 + i / 8, 1, fe_last && (i == n - 1));
    endtask

    // Called right after frame_end has been driven; lat = edges after T until update seen.
    task automatic wait_update(input int budget, output int lat);
        lat = -1;
        @(posedge clock);
        for (int k = 1; k <= budget; k++) begin
            idle();
            @(posedge clock);
            #1;
            if (bus.update) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic check_outputs(input string tag, input int x, input int y, input int e);
        check({tag, "_x"}, int'(bus.x_pos), x);
        check({tag, "_y"}, int'(bus.y_pos), y);
        check({tag, "_en"}, int'(bus.en), e);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, nupd, first_k, len, gap;
        bus.pix_valid = 0; bus.pix_x = '0; bus.pix_y = '0; bus.pix_match = 0; bus.frame_end = 0;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        repeat (4) idle();
        @(posedge clock); #1;
        check_outputs("reset", 160, 120, 0);
        check("reset_update", int'(bus.update), 0);
        check("reset_busy", int'(bus.busy), 0);

        // 64-pixel block
        block(100, 50, 64, 0);
        drive(0, 0, 0, 0, 1);
        wait_update(40, lat);
        check("block64_lat", lat, 26);
        check_outputs("block64", 103, 53, 1);

        // 63 pixels: below threshold, position holds
        block(100, 50, 63, 0);
        drive(0, 0, 0, 0, 1);
        wait_update(40, lat);
        check("block63_lat", lat, 1);
        check_outputs("block63", 103, 53, 0);
        check("block63_busy", int'(bus.busy), 0);

        // full screen
        for (int y = 0; y < 240; y++)
            for (int x = 0; x < 320; x++)
                drive(1, x, y, 1, 0);
        drive(0, 0, 0, 0, 1);
        wait_update(40, lat);
        check("full_lat", lat, 26);
        check_outputs("full", 159, 119, 1);

        // out-of-range and unmatched pixels mixed in; last pixel coincides with frame_end
        drive(1, 320, 52, 1, 0);
        drive(1, 103, 240, 1, 0);
        block(100, 50, 30, 0);
        drive(1, 104, 52, 0, 0);
        drive(1, 511, 255, 1, 0);
        for (int i = 30; i < 64; i++)
            drive(1, 100 + i % 8, 50 + i / 8, 1, i == 63);
        wait_update(40, lat);
        check("range_lat", lat, 26);
        check_outputs("range", 103, 53, 1);

        // overrun frame_end during DIVIDE
        block(200, 10, 64, 0);
        drive(0, 0, 0, 0, 1);
        @(posedge clock);
        nupd = 0; first_k = -1;
        for (int k = 1; k <= 60; k++) begin
            drive(0, 0, 0, 0, k == 10);
            @(posedge clock); #1;
            if (bus.update) begin
                nupd++;
                if (first_k < 0) first_k = k;
            end
        end
        check("overrun_updates", nupd, 1);
        check("overrun_lat", first_k, 26);
        check_outputs("overrun", 203, 13, 1);
        block(100, 50, 64, 0);
        drive(0, 0, 0, 0, 1);
        wait_update(40, lat);
        check("after_overrun_lat", lat, 26);
        check_outputs("after_overrun", 103, 53, 1);

        // reset mid-DIVIDE
        block(200, 10, 64, 0);
        drive(0, 0, 0, 0, 1);
        @(posedge clock);
        for (int k = 1; k <= 11; k++) idle();
        @(negedge clock);
        reset_n = 1'b0;
        #1;
        check_outputs("abort", 160, 120, 0);
        check("abort_update", int'(bus.update), 0);
        check("abort_busy", int'(bus.busy), 0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        nupd = 0;
        for (int k = 0; k < 40; k++) begin
            idle();
            @(posedge clock); #1;
            if (bus.update) nupd++;
        end
        check("abort_no_update", nupd, 0);

        // randomized frames, some short enough to overrun
        for (int f = 0; f < 30; f++) begin
            len = ($urandom % 4 == 0) ? int'($urandom_range(1, 30)) : int'($urandom_range(100, 260));
            for (int i = 0; i < len; i++)
                drive(($urandom % 8) != 0, int'($urandom_range(0, 335)), int'($urandom_range(0, 250)),
                      ($urandom % 3) != 0, i == len - 1);
            gap = int'($urandom_range(0, 35));
            for (int i = 0; i < gap; i++) idle();
            if (f == 15) begin
                @(negedge clock);
                reset_n = 1'b0;
                idle();
                @(negedge clock);
                reset_n = 1'b1;
            end
        end
        repeat (40) idle();
        @(posedge clock); #2;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
